// File: rtl/ca_vram_if.sv
// ca_vram_if: control inputs and VRAM write port of the cellular-automaton writer.
interface ca_vram_if #(parameter int ADDR_W = 20);
    logic [7:0]        rule;
    logic              seed_sel;
    logic              step;
    logic              restart;
    logic [ADDR_W-1:0] write_addr;
    logic              wdata;
    logic              write_en;
    logic              busy;
    logic [6:0]        row;
    logic [15:0]       generation;
    modport master (
        input  rule, seed_sel, step, restart,
        output write_addr, wdata, write_en, busy, row, generation
    );
    modport slave (
        output rule, seed_sel, step, restart,
        input  write_addr, wdata, write_en, busy, row, generation
    );
endinterface

// File: rtl/ca_vram_writer.sv
// ca_vram_writer: elementary cellular automaton that streams each new generation into a scrolling 1-bit VRAM.
module ca_vram_writer #(
    parameter int WIDTH     = 160,
    parameter int HEIGHT    = 120,
    parameter int ADDR_W    = 20,
    parameter int EDGE_WRAP = 0
) (
    input  logic       clk,
    input  logic       reset,
    ca_vram_if.master  bus
);
    localparam int CW = $clog2(WIDTH * HEIGHT + 1);
    typedef enum logic [2:0] {CLEAR, SEED, IDLE, COMPUTE, WRITE} state_t;
    state_t            state, nstate;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  cur, sh, nxt;
    logic [WIDTH+1:0]  ext;
    logic [ADDR_W-1:0] base;
    logic [15:0]       lfsr;
    logic              seed_bit, last_clear, last_col, row_done;
    logic [6:0]        nrow;
    always_ff @(posedge clk)
        if (reset) state <= CLEAR;
        else state <= nstate;
    always_comb begin
        nstate = state;
        case (state)
            CLEAR:   nstate = last_clear ? SEED : CLEAR;
            SEED:    nstate = last_col ? IDLE : SEED;
            IDLE:    nstate = bus.restart ? CLEAR : bus.step ? COMPUTE : IDLE;
            COMPUTE: nstate = WRITE;
            WRITE:   nstate = row_done ? IDLE : WRITE;
            default: nstate = CLEAR;
        endcase
    end
    always_comb begin
        bus.busy   = state != IDLE;
        last_clear = cnt == CW'(WIDTH * HEIGHT - 1);
        last_col   = cnt == CW'(WIDTH - 1);
        row_done   = cnt == CW'(WIDTH);
        seed_bit   = bus.seed_sel ? lfsr[0] : cnt == CW'(WIDTH / 2);
        nrow       = (bus.row == 7'(HEIGHT - 1)) ? 7'd0 : bus.row + 7'd1;
        // ext[i+1] is cell i; the two guard cells carry the wrapped or zero neighbours
        ext        = {(EDGE_WRAP != 0) & cur[0], cur, (EDGE_WRAP != 0) & cur[WIDTH-1]};
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_rule
        assign nxt[i] = bus.rule[{ext[i], ext[i+1], ext[i+2]}];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt            <= '0;
            bus.write_en   <= 1'b0;
            bus.wdata      <= 1'b0;
            bus.write_addr <= '0;
            bus.row        <= '0;
            bus.generation <= '0;
            lfsr           <= 16'hACE1;
            cur            <= '0;
            sh             <= '0;
            base           <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    bus.write_en   <= 1'b1;
                    bus.wdata      <= 1'b0;
                    bus.write_addr <= ADDR_W'(cnt);
                    cnt            <= last_clear ? '0 : cnt + 1'b1;
                end
                SEED: begin
                    bus.write_en   <= 1'b1;
                    bus.wdata      <= seed_bit;
                    bus.write_addr <= ADDR_W'(cnt);
                    cur            <= {seed_bit, cur[WIDTH-1:1]};
                    lfsr           <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
                    cnt            <= last_col ? '0 : cnt + 1'b1;
                    bus.row        <= '0;
                    bus.generation <= '0;
                    base           <= '0;
                end
                IDLE: begin
                    bus.write_en <= 1'b0;
                    cnt          <= '0;
                end
                COMPUTE: begin
                    bus.write_en   <= 1'b1;
                    bus.wdata      <= nxt[0];
                    bus.write_addr <= (nrow == 7'd0) ? '0 : base + ADDR_W'(WIDTH);
                    base           <= (nrow == 7'd0) ? '0 : base + ADDR_W'(WIDTH);
                    bus.row        <= nrow;
                    cur            <= nxt;
                    sh             <= nxt >> 1;
                    cnt            <= CW'(1);
                end
                WRITE: begin
                    // the extra cycle after the last column keeps busy high until write_en drops
                    if (row_done) begin
                        bus.write_en   <= 1'b0;
                        bus.generation <= bus.generation + 1'b1;
                    end else begin
                        bus.write_en   <= 1'b1;
                        bus.wdata      <= sh[0];
                        bus.write_addr <= base + ADDR_W'(cnt);
                        sh             <= sh >> 1;
                        cnt            <= cnt + 1'b1;
                    end
                end
                default: bus.write_en <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_ca_vram_writer.sv
// tb_ca_vram_writer: scoreboard bench; a zero-edge and a wrapping instance share stimulus,
// each VRAM write is popped from a queue of expected {addr, data} filled when stimulus is driven.
module tb_ca_vram_writer;
    localparam int W = 160;
    localparam int H = 120;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    ca_vram_if #(.ADDR_W(20)) v0();
    ca_vram_if #(.ADDR_W(20)) v1();
    assign v1.rule     = v0.rule;
    assign v1.seed_sel = v0.seed_sel;
    assign v1.step     = v0.step;
    assign v1.restart  = v0.restart;
    ca_vram_writer #(.EDGE_WRAP(0)) dut0 (.clk(clk), .reset(reset), .bus(v0));
    ca_vram_writer #(.EDGE_WRAP(1)) dut1 (.clk(clk), .reset(reset), .bus(v1));
    int n_chk = 0;
    int n_fail = 0;
    logic [20:0] q0[$];
    logic [20:0] q1[$];
    logic [W-1:0] cur0, cur1;
    int mrow, mgen;
    logic [15:0] lfsr_m;
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    always @(posedge clk) begin
        #1;
        if (v0.write_en) begin
            if (q0.size() == 0) check("wr0_unexpected", {11'd0, v0.write_addr, v0.wdata}, 32'hFFFFFFFF);
            else check("wr0", {11'd0, v0.write_addr, v0.wdata}, {11'd0, q0.pop_front()});
        end
        if (v1.write_en) begin
            if (q1.size() == 0) check("wr1_unexpected", {11'd0, v1.write_addr, v1.wdata}, 32'hFFFFFFFF);
            else check("wr1", {11'd0, v1.write_addr, v1.wdata}, {11'd0, q1.pop_front()});
        end
    end
    function automatic logic [W-1:0] next_gen(input logic [W-1:0] c, input logic [7:0] r, input bit wrap);
        logic [W-1:0] n;
        logic l, rt;
        for (int i = 0; i < W; i++) begin
            if (i == 0) l = wrap ? c[W-1] : 1'b0;
            else l = c[i-1];
            if (i == W - 1) rt = wrap ? c[0] : 1'b0;
            else rt = c[i+1];
            n[i] = r[{l, c[i], rt}];
        end
        return n;
    endfunction
    task automatic push_init(input bit sel);
        logic b;
        for (int i = 0; i < W * H; i++) begin
            q0.push_back({20'(i), 1'b0});
            q1.push_back({20'(i), 1'b0});
        end
        for (int c = 0; c < W; c++) begin
            b = sel ? lfsr_m[0] : (c == W / 2);
            lfsr_m = {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
            q0.push_back({20'(c), b});
            q1.push_back({20'(c), b});
            cur0[c] = b;
            cur1[c] = b;
        end
        mrow = 0;
        mgen = 0;
    endtask
    task automatic push_gen(input logic [7:0] r);
        cur0 = next_gen(cur0, r, 1'b0);
        cur1 = next_gen(cur1, r, 1'b1);
        mrow = (mrow == H - 1) ? 0 : mrow + 1;
        for (int c = 0; c < W; c++) begin
            q0.push_back({20'(mrow * W + c), cur0[c]});
            q1.push_back({20'(mrow * W + c), cur1[c]});
        end
        mgen++;
    endtask
    task automatic wait_idle(input int limit, output int cyc);
        cyc = 0;
        while (v0.busy && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        if (v0.busy) check("idle_timeout", {31'd0, v0.busy}, 32'd0);
    endtask
    task automatic do_step(input logic [7:0] r, output int lat);
        int cyc;
        @(negedge clk);
        v0.rule = r;
        v0.step = 1'b1;
        push_gen(r);
        @(negedge clk);
        v0.step = 1'b0;
        wait_idle(1000, cyc);
        lat = cyc + 1;
    endtask
    initial begin
        int cyc, lat;
        v0.rule = 8'd90;
        v0.seed_sel = 1'b0;
        v0.step = 1'b0;
        v0.restart = 1'b0;
        lfsr_m = 16'hACE1;
        push_init(1'b0);
        @(posedge clk);
        @(negedge clk);
        check("rst_we", {31'd0, v0.write_en}, 32'd0);
        check("rst_addr", {12'd0, v0.write_addr}, 32'd0);
        check("rst_busy", {31'd0, v0.busy}, 32'd1);
        check("rst_row", {25'd0, v0.row}, 32'd0);
        check("rst_gen", {16'd0, v0.generation}, 32'd0);
        reset = 1'b0;
        wait_idle(25000, cyc);
        check("init_cycles", cyc, 32'd19360);
        check("init_q0", q0.size(), 32'd0);
        check("init_q1", q1.size(), 32'd0);
        do_step(8'd90, lat);
        check("step_latency", lat, 32'd162);
        check("step_gen", {16'd0, v0.generation}, mgen);
        check("step_row", {25'd0, v0.row}, mrow);
        check("step_we_low", {31'd0, v0.write_en}, 32'd0);
        @(negedge clk);
        v0.step = 1'b1;
        push_gen(8'd90);
        push_gen(8'd90);
        repeat (320) @(negedge clk);
        v0.step = 1'b0;
        wait_idle(400, cyc);
        check("held_gen", {16'd0, v0.generation}, 32'd3);
        check("held_q0", q0.size(), 32'd0);
        @(negedge clk);
        v0.step = 1'b1;
        v0.restart = 1'b1;
        push_init(1'b0);
        @(negedge clk);
        v0.step = 1'b0;
        v0.restart = 1'b0;
        wait_idle(25000, cyc);
        check("restart_gen", {16'd0, v0.generation}, 32'd0);
        check("restart_row", {25'd0, v0.row}, 32'd0);
        check("restart_q0", q0.size(), 32'd0);
        for (int s = 0; s < 81; s++) do_step(8'd170, lat);
        check("r170_row", {25'd0, v0.row}, 32'd81);
        check("r170_q0", q0.size(), 32'd0);
        check("r170_q1", q1.size(), 32'd0);
        for (int s = 0; s < 39; s++) do_step(8'd30, lat);
        check("wrap_row", {25'd0, v0.row}, 32'd0);
        check("wrap_gen", {16'd0, v0.generation}, 32'd120);
        check("wrap_q0", q0.size(), 32'd0);
        @(negedge clk);
        v0.seed_sel = 1'b1;
        v0.rule = 8'd30;
        v0.step = 1'b1;
        push_gen(8'd30);
        @(negedge clk);
        v0.step = 1'b0;
        repeat (51) @(negedge clk);
        check("abort_q0", q0.size(), 32'd109);
        reset = 1'b1;
        q0.delete();
        q1.delete();
        lfsr_m = 16'hACE1;
        push_init(1'b1);
        @(negedge clk);
        check("abort_we", {31'd0, v0.write_en}, 32'd0);
        check("abort_gen", {16'd0, v0.generation}, 32'd0);
        check("abort_addr", {12'd0, v0.write_addr}, 32'd0);
        check("abort_busy", {31'd0, v0.busy}, 32'd1);
        reset = 1'b0;
        wait_idle(25000, cyc);
        check("reinit_cycles", cyc, 32'd19360);
        check("reinit_q0", q0.size(), 32'd0);
        check("reinit_q1", q1.size(), 32'd0);
        do_step(8'd30, lat);
        check("lfsr_step_gen", {16'd0, v0.generation}, 32'd1);
        check("final_q0", q0.size(), 32'd0);
        check("final_q1", q1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
